// File: rtl/gate_sweep_checker.sv
// Sweeps {a,b} through 00,01,10,11 into a two-input gate block and
// checks the eight returned gate results against their golden values.
// Ports: clk, rst (async, active-high), start; a, b stimulus out;
//   an_d, o_r, no_t, no_t_b, na_nd, no_r, ex_or, ex_nor results in;
//   busy, done, pass status; err_count, err_mask, fail_bits results.
module gate_sweep_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       an_d,
  input  logic       o_r,
  input  logic       no_t,
  input  logic       no_t_b,
  input  logic       na_nd,
  input  logic       no_r,
  input  logic       ex_or,
  input  logic       ex_nor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask,
  output logic [7:0] fail_bits
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t     state, state_n;
  logic [1:0] vec, vec_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] ec_n;
  logic [3:0] em_n;
  logic [7:0] fb_n;
  logic [7:0] golden;
  logic [7:0] obs;
  logic [7:0] diff;

  assign a = vec[1];
  assign b = vec[0];

  assign golden = {
    ~(a ^ b), a ^ b, ~(a | b), ~(a & b),
    ~b, ~a, a | b, a & b
  };
  assign obs = {
    ex_nor, ex_or, no_r, na_nd,
    no_t_b, no_t, o_r, an_d
  };
  assign diff = obs ^ golden;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      vec       <= 2'd0;
      cnt       <= 4'd0;
      err_count <= 3'd0;
      err_mask  <= 4'd0;
      fail_bits <= 8'd0;
    end else begin
      state     <= state_n;
      vec       <= vec_n;
      cnt       <= cnt_n;
      err_count <= ec_n;
      err_mask  <= em_n;
      fail_bits <= fb_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    ec_n    = err_count;
    em_n    = err_mask;
    fb_n    = fail_bits;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_n   = 2'd0;
          cnt_n   = SETTLE_LD;
          ec_n    = 3'd0;
          em_n    = 4'd0;
          fb_n    = 8'd0;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // counter holds remaining settle cycles including this one
        if (cnt <= 4'd1) begin
          cnt_n   = 4'd0;
          state_n = S_CHECK;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_CHECK: begin
        if (|diff) begin
          if (err_count < 3'd4)
            ec_n = err_count + 3'd1;
          em_n = err_mask | (4'b0001 << vec);
          fb_n = fail_bits | diff;
        end
        if (vec == 2'd3) begin
          state_n = S_DONE;
        end else begin
          vec_n   = vec + 2'd1;
          cnt_n   = SETTLE_LD;
          state_n = S_SETTLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 3'd0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: three checkers (SETTLE 2, 1, 15) driving a modelled
// gate block with selectable faults; expected values are hand-derived.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [2:0] a_v, b_v, busy_v, done_v, pass_v;
  logic [2:0] ec[3];
  logic [3:0] em[3];
  logic [7:0] fb[3];
  logic [7:0] g[3];

  function automatic logic [7:0] gates(logic x, logic y, int m);
    logic [7:0] r;
    r = {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~y, ~x, x | y, x & y};
    if (m == 1) r[0] = 1'b0;
    if (m == 2) r[7:6] = ~r[7:6];
    return r;
  endfunction

  assign g[0] = gates(a_v[0], b_v[0], mode);
  assign g[1] = gates(a_v[1], b_v[1], mode);
  assign g[2] = gates(a_v[2], b_v[2], mode);

  gate_sweep_checker #(.SETTLE(2)) u0 (
    .clk(clk), .rst(rst), .start(start),
    .a(a_v[0]), .b(b_v[0]),
    .an_d(g[0][0]), .o_r(g[0][1]), .no_t(g[0][2]), .no_t_b(g[0][3]),
    .na_nd(g[0][4]), .no_r(g[0][5]), .ex_or(g[0][6]), .ex_nor(g[0][7]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(ec[0]), .err_mask(em[0]), .fail_bits(fb[0])
  );

  gate_sweep_checker #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start),
    .a(a_v[1]), .b(b_v[1]),
    .an_d(g[1][0]), .o_r(g[1][1]), .no_t(g[1][2]), .no_t_b(g[1][3]),
    .na_nd(g[1][4]), .no_r(g[1][5]), .ex_or(g[1][6]), .ex_nor(g[1][7]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(ec[1]), .err_mask(em[1]), .fail_bits(fb[1])
  );

  gate_sweep_checker #(.SETTLE(15)) u2 (
    .clk(clk), .rst(rst), .start(start),
    .a(a_v[2]), .b(b_v[2]),
    .an_d(g[2][0]), .o_r(g[2][1]), .no_t(g[2][2]), .no_t_b(g[2][3]),
    .na_nd(g[2][4]), .no_r(g[2][5]), .ex_or(g[2][6]), .ex_nor(g[2][7]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(ec[2]), .err_mask(em[2]), .fail_bits(fb[2])
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulse start, then time busy-rise to done-rise on every instance.
  task automatic sweep(input bit hammer, output int l0, l1, l2);
    int bs[3];
    int ds[3];
    int l[3];
    for (int i = 0; i < 3; i++) begin
      bs[i] = -1;
      ds[i] = -1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i] && bs[i] < 0) bs[i] = c;
        if (done_v[i] && ds[i] < 0) ds[i] = c;
      end
      if (c % 3 == 0 && c < 12)
        chk("ab_step", int'({a_v[0], b_v[0]}), c / 3);
      if (ds[0] >= 0 && ds[1] >= 0 && ds[2] >= 0) break;
      if (hammer) start = (c < 7) && (c % 2 == 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++)
      l[i] = (bs[i] >= 0 && ds[i] >= 0) ? ds[i] - bs[i] : -1;
    l0 = l[0];
    l1 = l[1];
    l2 = l[2];
  endtask

  task automatic results(input int e_ec, input int e_em,
                         input int e_fb, input int e_pass);
    for (int i = 0; i < 3; i++) begin
      chk("err_count", int'(ec[i]), e_ec);
      chk("err_mask", int'(em[i]), e_em);
      chk("fail_bits", int'(fb[i]), e_fb);
      chk("pass", int'(pass_v[i]), e_pass);
    end
  endtask

  int l0, l1, l2;
  int n;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    #12;
    chk("rst_busy", int'(busy_v), 0);
    chk("rst_done", int'(done_v), 0);
    chk("rst_pass", int'(pass_v), 0);
    chk("rst_ab", int'({a_v[0], b_v[0]}), 0);
    chk("rst_ec", int'(ec[0]), 0);
    chk("rst_em", int'(em[0]), 0);
    chk("rst_fb", int'(fb[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // clean gate block
    sweep(1'b0, l0, l1, l2);
    chk("len_s2", l0, 12);
    chk("len_s1", l1, 8);
    chk("len_s15", l2, 64);
    results(0, 0, 0, 1);

    // an_d stuck at 0, start hammered during the sweep
    mode = 1;
    sweep(1'b1, l0, l1, l2);
    chk("len_hammer_s2", l0, 12);
    chk("len_hammer_s1", l1, 8);
    results(1, 8, 8'h01, 0);

    // DONE holds results
    repeat (5) @(posedge clk);
    #1;
    chk("hold_ec", int'(ec[0]), 1);
    chk("hold_done", int'(done_v[0]), 1);

    // restart from DONE clears on the next edge
    mode = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", int'(busy_v[0]), 1);
    chk("restart_ec", int'(ec[0]), 0);
    chk("restart_em", int'(em[0]), 0);
    chk("restart_fb", int'(fb[0]), 0);
    n = 0;
    while (done_v != 3'b111 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_timeout", int'(n < 100), 1);
    results(4, 15, 8'hC0, 0);

    // reset during vector 2 settle
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_ab", int'({a_v[0], b_v[0]}), 2);
    chk("mid_ec", int'(ec[0]), 2);
    rst = 1'b1;
    #1;
    chk("arst_ab", int'({a_v[0], b_v[0]}), 0);
    chk("arst_busy", int'(busy_v[0]), 0);
    chk("arst_ec", int'(ec[0]), 0);
    chk("arst_em", int'(em[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy_v), 0);
    chk("idle_done", int'(done_v), 0);

    mode = 0;
    sweep(1'b0, l0, l1, l2);
    chk("post_len_s2", l0, 12);
    results(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 Parameter: SETTLE, default 2, number of wait cycles per input vector before outputs are sampled; legal range 1..15.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous, active-high.
REQ-004 Port: start  in  1  request a sweep; sampled on rising edge.
REQ-005 Port: a, b  out  1 each  stimulus driven into the downstream two-input gate dataflow block.
REQ-006 Port: an_d, o_r, no_t, no_t_b, na_nd, no_r, ex_or, ex_nor  in  1 each  gate results returned from the gate dataflow block.
REQ-007 Port: busy  out  1  high while a sweep is in progress.
REQ-008 Port: done  out  1  high in DONE state.
REQ-009 Port: pass  out  1  high when done=1 and err_count=0.
REQ-010 Port: err_count  out  3  number of failing vectors, 0..4.
REQ-011 Port: err_mask  out  4  bit i set if vector i ({a,b}=i) failed.
REQ-012 Port: fail_bits  out  8  sticky OR of mismatching result positions; bit order [7:0] = {ex_nor, ex_or, no_r, na_nd, no_t_b, no_t, o_r, an_d}.

Function
REQ-013 States SHALL be IDLE, SETTLE, CHECK, DONE; encoding is free.
REQ-014 {a,b} SHALL be driven from a registered 2-bit vector index vec (a=vec[1], b=vec[0]).
REQ-015 IDLE with start=1 SHALL, on the next edge, set vec=0, clear err_count/err_mask/fail_bits, load the settle counter, and enter SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE cycles, then enter CHECK.
REQ-017 CHECK SHALL last one cycle and compare the 8 inputs against golden values: an_d=a&b, o_r=a|b, no_t=~a, no_t_b=~b, na_nd=~(a&b), no_r=~(a|b), ex_or=a^b, ex_nor=~(a^b).
REQ-018 On any mismatch in CHECK: err_count SHALL increment by 1 (once per vector regardless of bit count), err_mask[vec] SHALL be set, and mismatching positions SHALL be ORed into fail_bits.
REQ-019 From CHECK with vec<3: vec SHALL increment, settle counter reload, next state SETTLE; with vec=3: vec SHALL hold at 3 and next state DONE.
REQ-020 A full sweep SHALL take 4*(SETTLE+1) cycles from busy rising to done rising (12 cycles at SETTLE=2).
REQ-021 busy SHALL be 1 in SETTLE and CHECK, 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 DONE SHALL hold all results stable until start=1, which SHALL behave exactly as REQ-015 (results cleared, new sweep).
REQ-024 err_count SHALL never exceed 4; no wrap-around.
REQ-025 Inputs SHALL be sampled only in CHECK; input changes in other states SHALL have no effect.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, vec=0 (a=0, b=0), busy=0, done=0, pass=0, err_count=0, err_mask=0, fail_bits=0, settle counter=0.
REQ-027 rst asserted mid-sweep SHALL abort the sweep with no partial results retained; start is accepted on the first edge after rst deasserts.

Verification
REQ-028 Correct gate block connected, SETTLE=2, pulse start -> busy for 12 cycles, {a,b} steps 00,01,10,11 every 3 cycles, then done=1, pass=1, err_count=0, err_mask=0, fail_bits=8'h00.
REQ-029 an_d forced to 0 -> only vector 3 fails: err_count=1, err_mask=4'b1000, fail_bits=8'h01, pass=0.
REQ-030 ex_or and ex_nor both inverted -> all vectors fail: err_count=4, err_mask=4'b1111, fail_bits=8'hC0, pass=0.
REQ-031 start pulsed repeatedly during a sweep -> sweep length unchanged (12 cycles at SETTLE=2), no restart; start in DONE after a failing sweep -> results cleared on the next edge, new sweep runs.
REQ-032 rst asserted during vector 2 SETTLE -> same cycle: a=0, b=0, busy=0, err_count=0; after release, IDLE holds until start.
REQ-033 SETTLE=1 and SETTLE=15 builds -> sweep lengths 8 and 64 cycles respectively, results identical to REQ-028.
